// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the CPU memory arbiter: FSM state encoding and access size codes.
package cpu_mem_arbiter_pkg;

   localparam int unsigned DW = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_D_ADDR = 3'd1,
      ST_D_DATA = 3'd2,
      ST_I_ADDR = 3'd3,
      ST_I_DATA = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_t;

endpackage

// File: rtl/cpu_mem_arbiter_slot.sv
// One requester's completion state: done flag plus the last returned read word.
module mem_port_slot
   import cpu_mem_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          complete_i,
   input  logic          load_i,
   input  logic          clear_i,
   input  logic [DW-1:0] rdata_i,
   output logic          done_o,
   output logic [DW-1:0] rdata_o
);

   logic          done_q, done_d;
   logic [DW-1:0] rdata_q, rdata_d;

   // A completion on the same edge as a clear wins, so a finished access is never lost.
   always_comb begin
      done_d  = done_q;
      rdata_d = rdata_q;
      if (clear_i) begin
         done_d = 1'b0;
      end
      if (complete_i) begin
         done_d = 1'b1;
         if (load_i) begin
            rdata_d = rdata_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   assign done_o  = done_q;
   assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-outstanding memory bus.
// Handshake: bus_req holds with stable fields until bus_addr_ok; then one bus_data_ok ends it.
module cpu_mem_arbiter
   import cpu_mem_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          inst_req,
   input  logic [DW-1:0] inst_addr,
   output logic [DW-1:0] inst_rdata,
   input  logic          data_req,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [DW-1:0] data_addr,
   input  logic [DW-1:0] data_wdata,
   output logic [DW-1:0] data_rdata,
   input  logic          ext_stall,
   input  logic          flush_except,
   output logic          i_stall,
   output logic          d_stall,
   output logic          bus_req,
   output logic          bus_wr,
   output logic [1:0]    bus_size,
   output logic [DW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_addr_ok,
   input  logic          bus_data_ok,
   input  logic [DW-1:0] bus_rdata,
   output logic [2:0]    dbg_state_o
);

   state_t        state_q, state_d;
   logic          discard_q, discard_d;
   logic          wr_q, wr_d;
   logic [1:0]    size_q, size_d;
   logic [DW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          i_done, d_done;
   logic          i_complete, d_complete;
   logic          advance;

   assign i_stall     = inst_req && !i_done;
   assign d_stall     = data_req && !d_done;
   assign advance     = !i_stall && !d_stall && !ext_stall;
   assign dbg_state_o = state_q;

   // Request fields are captured at issue so the bus stays stable even if the requester moves on.
   always_comb begin
      state_d    = state_q;
      discard_d  = discard_q;
      wr_d       = wr_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      bus_req    = 1'b0;
      i_complete = 1'b0;
      d_complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (data_req && !d_done) begin
               state_d = ST_D_ADDR;
               wr_d    = data_wr;
               size_d  = data_size;
               addr_d  = data_addr;
               wdata_d = data_wdata;
            end else if (inst_req && !i_done) begin
               state_d = ST_I_ADDR;
               wr_d    = 1'b0;
               size_d  = SIZE_WORD;
               addr_d  = inst_addr;
               wdata_d = '0;
            end
         end
         ST_D_ADDR: begin
            bus_req = 1'b1;
            if (bus_addr_ok) state_d = ST_D_DATA;
         end
         ST_D_DATA: begin
            if (bus_data_ok) begin
               d_complete = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         ST_I_ADDR: begin
            bus_req = 1'b1;
            if (flush_except) discard_d = 1'b1;
            if (bus_addr_ok) state_d = ST_I_DATA;
         end
         ST_I_DATA: begin
            if (bus_data_ok) begin
               // A flush landing on the completion cycle still drops the fetched word.
               i_complete = !(discard_q || flush_except);
               discard_d  = 1'b0;
               state_d    = ST_IDLE;
            end else if (flush_except) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         discard_q <= 1'b0;
         wr_q      <= 1'b0;
         size_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign bus_wr    = bus_req ? wr_q : 1'b0;
   assign bus_size  = bus_req ? size_q : 2'd0;
   assign bus_addr  = bus_req ? addr_q : '0;
   assign bus_wdata = bus_req ? wdata_q : '0;

   mem_port_slot u_inst_slot (
      .clk        (clk),
      .rst        (rst),
      .complete_i (i_complete),
      .load_i     (1'b1),
      .clear_i    (advance || (state_q == ST_IDLE && flush_except)),
      .rdata_i    (bus_rdata),
      .done_o     (i_done),
      .rdata_o    (inst_rdata)
   );

   mem_port_slot u_data_slot (
      .clk        (clk),
      .rst        (rst),
      .complete_i (d_complete),
      .load_i     (!wr_q),
      .clear_i    (advance),
      .rdata_i    (bus_rdata),
      .done_o     (d_done),
      .rdata_o    (data_rdata)
   );

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_cpu_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        ext_stall;
   logic        flush_except;
   logic        i_stall;
   logic        d_stall;
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;
   logic [2:0]  dbg_state;

   cpu_mem_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_rdata   (data_rdata),
      .ext_stall    (ext_stall),
      .flush_except (flush_except),
      .i_stall      (i_stall),
      .d_stall      (d_stall),
      .bus_req      (bus_req),
      .bus_wr       (bus_wr),
      .bus_size     (bus_size),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_addr_ok  (bus_addr_ok),
      .bus_data_ok  (bus_data_ok),
      .bus_rdata    (bus_rdata),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   typedef struct {
      logic        is_inst;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        acc;
      logic        disc;
   } txn_t;

   txn_t        txn_q[$];
   logic        m_idone, m_ddone;
   logic [31:0] m_ibuf, m_dbuf;
   logic        m_adv;
   int          total;
   int          bad;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic model_update();
      txn_t t;
      logic n_idone, n_ddone;
      m_adv = !(inst_req && !m_idone) && !(data_req && !m_ddone) && !ext_stall;
      if (rst) begin
         txn_q.delete();
         m_idone = 1'b0;
         m_ddone = 1'b0;
         m_ibuf  = '0;
         m_dbuf  = '0;
      end else begin
         n_idone = m_adv ? 1'b0 : m_idone;
         n_ddone = m_adv ? 1'b0 : m_ddone;
         if (txn_q.size() == 0) begin
            if (flush_except) n_idone = 1'b0;
            if (data_req && !m_ddone) begin
               t = '{1'b0, data_wr, data_size, data_addr, data_wdata, 1'b0, 1'b0};
               txn_q.push_back(t);
            end else if (inst_req && !m_idone) begin
               t = '{1'b1, 1'b0, 2'd2, inst_addr, 32'h0, 1'b0, 1'b0};
               txn_q.push_back(t);
            end
         end else begin
            t = txn_q.pop_front();
            if (t.is_inst && flush_except) t.disc = 1'b1;
            if (!t.acc) begin
               t.acc = bus_addr_ok;
               txn_q.push_back(t);
            end else if (bus_data_ok) begin
               if (t.is_inst) begin
                  if (!t.disc) begin
                     m_ibuf  = bus_rdata;
                     n_idone = 1'b1;
                  end
               end else begin
                  if (!t.wr) m_dbuf = bus_rdata;
                  n_ddone = 1'b1;
               end
            end else begin
               txn_q.push_back(t);
            end
         end
         m_idone = n_idone;
         m_ddone = n_ddone;
      end
   endtask

   task automatic check_model();
      logic exp_req;
      exp_req = (txn_q.size() != 0) && !txn_q[0].acc;
      chk("bus_req", 32'(bus_req), 32'(exp_req));
      if (exp_req) begin
         chk("bus_wr", 32'(bus_wr), 32'(txn_q[0].wr));
         chk("bus_size", 32'(bus_size), 32'(txn_q[0].size));
         chk("bus_addr", bus_addr, txn_q[0].addr);
         chk("bus_wdata", bus_wdata, txn_q[0].wdata);
      end
      chk("i_stall", 32'(i_stall), 32'(inst_req && !m_idone));
      chk("d_stall", 32'(d_stall), 32'(data_req && !m_ddone));
      chk("inst_rdata", inst_rdata, m_ibuf);
      chk("data_rdata", data_rdata, m_dbuf);
   endtask

   // ---------------- driver tasks ----------------
   task automatic at_neg();
      @(negedge clk);
      check_model();
   endtask

   task automatic at_pos();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive_slave(input int a_pct, input int d_pct, input int idle_pct);
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (txn_q.size() != 0) begin
         if (!txn_q[0].acc) bus_addr_ok = ($urandom_range(0, 99) < a_pct);
         else               bus_data_ok = ($urandom_range(0, 99) < d_pct);
      end else begin
         bus_data_ok = ($urandom_range(0, 99) < idle_pct);
      end
      bus_rdata = $urandom();
   endtask

   task automatic new_requests();
      inst_req   = ($urandom_range(0, 99) < 80);
      inst_addr  = 32'hBFC0_0000 | {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      data_req   = ($urandom_range(0, 99) < 40);
      data_wr    = $urandom_range(0, 1) == 1;
      data_size  = 2'($urandom_range(0, 2));
      data_addr  = 32'h8000_0000 | 32'($urandom_range(0, 65535));
      data_wdata = $urandom();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic pipe_moved;
      logic redirect;
      total = 0;
      bad = 0;
      txn_q.delete();
      m_idone = 0; m_ddone = 0; m_ibuf = 0; m_dbuf = 0; m_adv = 0;
      rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
      data_addr = 0; data_wdata = 0; ext_stall = 0; flush_except = 0;
      bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
      at_pos();
      at_neg();
      at_pos();
      rst = 0;
      chk("reset_bus_req", 32'(bus_req), 32'd0);
      chk("reset_inst_rdata", inst_rdata, 32'h0);
      chk("reset_data_rdata", data_rdata, 32'h0);

      // Zero-wait fetch.
      inst_req = 1; inst_addr = 32'hBFC0_0000;
      for (int c = 0; c < 4; c++) begin
         drive_slave(100, 100, 0);
         bus_rdata = 32'h2408_0001;
         at_neg();
         chk("fetch_bus_req", 32'(bus_req), 32'(c == 1));
         chk("fetch_i_stall", 32'(i_stall), 32'(c < 3));
         at_pos();
      end
      chk("fetch_rdata", inst_rdata, 32'h2408_0001);
      inst_req = 0;

      // Simultaneous data load and fetch: data side first.
      inst_req = 1; inst_addr = 32'hBFC0_0004;
      data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h8000_1000;
      for (int c = 0; c < 7; c++) begin
         drive_slave(100, 100, 0);
         bus_rdata = (c < 4) ? 32'hDA7A_0001 : 32'h1F00_D002;
         at_neg();
         if (c == 1) chk("both_first_addr", bus_addr, 32'h8000_1000);
         if (c == 4) chk("both_second_addr", bus_addr, 32'hBFC0_0004);
         chk("both_d_stall", 32'(d_stall), 32'(c < 3));
         chk("both_i_stall", 32'(i_stall), 32'(c < 6));
         at_pos();
      end
      chk("both_data_rdata", data_rdata, 32'hDA7A_0001);
      chk("both_inst_rdata", inst_rdata, 32'h1F00_D002);
      inst_req = 0; data_req = 0;

      // Byte store with delayed address acceptance.
      data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h8000_0003; data_wdata = 32'hAB;
      for (int c = 0; c < 7; c++) begin
         bus_addr_ok = (c == 4);
         bus_data_ok = (c == 5);
         bus_rdata   = 32'h5A5A_5A5A;
         at_neg();
         chk("store_bus_req", 32'(bus_req), 32'(c >= 1 && c <= 4));
         if (c >= 1 && c <= 4) begin
            chk("store_addr", bus_addr, 32'h8000_0003);
            chk("store_wdata", bus_wdata, 32'hAB);
            chk("store_wr_size", {30'h0, bus_wr, bus_size[0]}, 32'h2);
         end
         chk("store_d_stall", 32'(d_stall), 32'(c < 6));
         at_pos();
      end
      chk("store_data_rdata", data_rdata, 32'hDA7A_0001);
      data_req = 0; data_wr = 0;

      // Flush during the fetch data phase, redirect, then external stall.
      inst_req = 1; inst_addr = 32'hBFC0_0100;
      for (int c = 0; c < 13; c++) begin
         if (c >= 3) inst_addr = 32'hBFC0_0380;
         flush_except = (c == 2);
         ext_stall    = (c >= 7 && c < 12);
         if (c >= 4) begin
            drive_slave(100, 100, 0);
            bus_rdata = 32'h3C1D_A000;
         end else begin
            bus_addr_ok = (c == 1);
            bus_data_ok = (c == 3);
            bus_rdata   = 32'hDEAD_BEEF;
         end
         at_neg();
         if (c == 4) chk("flush_rdata_kept", inst_rdata, 32'h1F00_D002);
         if (c == 5) chk("flush_refetch_addr", bus_addr, 32'hBFC0_0380);
         chk("flush_i_stall", 32'(i_stall), 32'(c < 7));
         if (c >= 7) chk("hold_no_refetch", 32'(bus_req), 32'd0);
         at_pos();
      end
      chk("flush_new_rdata", inst_rdata, 32'h3C1D_A000);
      inst_req = 0; flush_except = 0; ext_stall = 0;

      // Reset in the middle of a data load; a stale data_ok afterwards is ignored.
      data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h8000_2000;
      for (int c = 0; c < 5; c++) begin
         rst         = (c == 2);
         bus_addr_ok = (c == 1);
         bus_data_ok = (c == 3);
         bus_rdata   = 32'h0000_0055;
         if (c == 3) data_req = 0;
         at_neg();
         if (c >= 3) begin
            chk("rst_bus_req", 32'(bus_req), 32'd0);
            chk("rst_data_rdata", data_rdata, 32'h0);
            chk("rst_inst_rdata", inst_rdata, 32'h0);
            chk("rst_state", 32'(dbg_state), 32'd0);
         end
         at_pos();
      end

      // Random traffic.
      pipe_moved = 1;
      redirect   = 0;
      for (int c = 0; c < 4000; c++) begin
         if (pipe_moved) new_requests();
         if (redirect) inst_addr = 32'hBFC0_0000 | {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
         rst          = ($urandom_range(0, 99) < 1);
         ext_stall    = ($urandom_range(0, 99) < 20);
         flush_except = ($urandom_range(0, 99) < 4);
         drive_slave(50, 50, 10);
         at_neg();
         at_pos();
         pipe_moved = m_adv || rst;
         redirect   = flush_except;
      end
      rst = 0; inst_req = 0; data_req = 0; flush_except = 0; ext_stall = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
